// File: rtl/ir_seq.sv
// Instruction-register sequencer: latches opcode, CB-page and interrupt state at
// instruction end, tracks the M-cycle index and drives the complementary pre-decode bus.
module ir_seq (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  D,
    input  logic        M_END,
    input  logic        INSTR_END,
    input  logic        CB_NEXT,
    input  logic        IRQ_REQ,
    input  logic        HALT,
    output logic [25:0] a,
    output logic [7:0]  IR,
    output logic [2:0]  MCYC,
    output logic        INT_ACK,
    output logic        CB_ACT
);

    localparam int unsigned IR_W   = 8;
    localparam int unsigned MCYC_W = 3;
    localparam logic [MCYC_W-1:0] MCYC_MAX = MCYC_W'(7);

    logic [IR_W-1:0]   ir_q,   ir_d;
    logic              cb_q,   cb_d;
    logic              irq_q,  irq_d;
    logic [MCYC_W-1:0] mcyc_q, mcyc_d;
    logic              int_ack_q, int_ack_d;
    logic              advance;

    // Sequencing state moves only on an unstalled M-cycle end.
    always_comb begin
        ir_d      = ir_q;
        cb_d      = cb_q;
        irq_d     = irq_q;
        mcyc_d    = mcyc_q;
        int_ack_d = 1'b0;
        advance   = M_END & ~HALT;
        if (advance) begin
            if (!INSTR_END) begin
                if (mcyc_q != MCYC_MAX) begin
                    mcyc_d = mcyc_q + MCYC_W'(1);
                end
            end else begin
                mcyc_d    = '0;
                cb_d      = CB_NEXT;
                irq_d     = IRQ_REQ & ~CB_NEXT;
                ir_d      = irq_d ? IR_W'(0) : D;
                int_ack_d = irq_d & ~irq_q;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ir_q      <= '0;
            cb_q      <= 1'b0;
            irq_q     <= 1'b0;
            mcyc_q    <= '0;
            int_ack_q <= 1'b0;
        end else begin
            ir_q      <= ir_d;
            cb_q      <= cb_d;
            irq_q     <= irq_d;
            mcyc_q    <= mcyc_d;
            int_ack_q <= int_ack_d;
        end
    end

    // Pre-decode bus is a pure rewiring of flop outputs, so each true/complement pair stays exact.
    always_comb begin
        a    = '0;
        a[0] = ~irq_q;
        a[1] = irq_q;
        a[2] = ~cb_q;
        a[3] = cb_q;
        for (int i = 0; i < 8; i++) begin
            a[4 + 2*i] = ir_q[7 - i];
            a[5 + 2*i] = ~ir_q[7 - i];
        end
        for (int j = 0; j < 3; j++) begin
            a[20 + 2*j] = mcyc_q[2 - j];
            a[21 + 2*j] = ~mcyc_q[2 - j];
        end
    end

    assign IR      = ir_q;
    assign MCYC    = mcyc_q;
    assign INT_ACK = int_ack_q;
    assign CB_ACT  = cb_q;

endmodule

// File: tb/tb_ir_seq.sv
// Bench for ir_seq: directed scenarios plus a randomized run against a
// behavioural model of the opcode/interrupt/M-cycle rules.
module tb_ir_seq;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [7:0]  D = '0;
    logic        M_END = 1'b0;
    logic        INSTR_END = 1'b0;
    logic        CB_NEXT = 1'b0;
    logic        IRQ_REQ = 1'b0;
    logic        HALT = 1'b0;
    logic [25:0] a;
    logic [7:0]  IR;
    logic [2:0]  MCYC;
    logic        INT_ACK;
    logic        CB_ACT;

    int total = 0;
    int bad   = 0;

    // Reference state
    logic [7:0] m_ir   = '0;
    logic       m_cb   = 1'b0;
    logic       m_irq  = 1'b0;
    int         m_mcyc = 0;
    logic       m_ack  = 1'b0;

    ir_seq dut (
        .CLK(CLK), .RESET(RESET), .D(D), .M_END(M_END), .INSTR_END(INSTR_END),
        .CB_NEXT(CB_NEXT), .IRQ_REQ(IRQ_REQ), .HALT(HALT),
        .a(a), .IR(IR), .MCYC(MCYC), .INT_ACK(INT_ACK), .CB_ACT(CB_ACT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [25:0] exp_a();
        logic [25:0] v;
        logic [2:0]  mc;
        mc = 3'(m_mcyc);
        v = '0;
        v[0] = !m_irq;  v[1] = m_irq;
        v[2] = !m_cb;   v[3] = m_cb;
        for (int i = 0; i < 8; i++) begin
            v[4 + 2*i] = m_ir[7 - i];
            v[5 + 2*i] = !m_ir[7 - i];
        end
        for (int j = 0; j < 3; j++) begin
            v[20 + 2*j] = mc[2 - j];
            v[21 + 2*j] = !mc[2 - j];
        end
        return v;
    endfunction

    task automatic model_reset();
        m_ir = '0; m_cb = 1'b0; m_irq = 1'b0; m_mcyc = 0; m_ack = 1'b0;
    endtask

    // Applies the rules to the inputs that will be seen at the coming edge.
    task automatic model_step();
        logic new_irq;
        if (RESET) begin
            model_reset();
        end else begin
            m_ack = 1'b0;
            if (M_END && !HALT) begin
                if (!INSTR_END) begin
                    m_mcyc = (m_mcyc >= 7) ? 7 : m_mcyc + 1;
                end else begin
                    new_irq = IRQ_REQ && !CB_NEXT;
                    m_ack   = new_irq && !m_irq;
                    m_irq   = new_irq;
                    m_cb    = CB_NEXT;
                    m_mcyc  = 0;
                    m_ir    = new_irq ? 8'h00 : D;
                end
            end
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".IR"},      32'(IR),      32'(m_ir));
        chk({tag, ".MCYC"},    32'(MCYC),    32'(m_mcyc));
        chk({tag, ".CB_ACT"},  32'(CB_ACT),  32'(m_cb));
        chk({tag, ".INT_ACK"}, 32'(INT_ACK), 32'(m_ack));
        chk({tag, ".a"},       32'(a),       32'(exp_a()));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge CLK);
        #1;
        chk_all(tag);
    endtask

    task automatic drive(input logic me, input logic ie, input logic cbn,
                         input logic irq, input logic [7:0] d, input logic h);
        M_END = me; INSTR_END = ie; CB_NEXT = cbn; IRQ_REQ = irq; D = d; HALT = h;
    endtask

    // Every true/complement pair must differ on every cycle.
    always @(negedge CLK) begin
        logic [12:0] pairs;
        for (int k = 0; k < 13; k++) pairs[k] = a[2*k] ^ a[2*k + 1];
        chk("complement", 32'(pairs), 32'h1FFF);
    end

    initial begin
        #1 RESET = 1'b1;
        #1;
        chk("rst.a",    32'(a),       32'h2AAAAA5);
        chk("rst.IR",   32'(IR),      32'h00);
        chk("rst.MCYC", 32'(MCYC),    32'd0);
        chk("rst.ack",  32'(INT_ACK), 32'd0);
        RESET = 1'b0;
        model_reset();

        // Opcode fetch then one non-final M-cycle
        drive(1, 1, 0, 0, 8'h3E, 0);
        tick("fetch");
        chk("fetch.IR", 32'(IR), 32'h3E);
        chk("fetch.a4_5", 32'({a[5], a[4]}), 32'b10);
        chk("fetch.a18_19", 32'({a[19], a[18]}), 32'b10);
        drive(1, 0, 0, 0, 8'h00, 0);
        tick("m1");
        chk("m1.MCYC", 32'(MCYC), 32'd1);
        chk("m1.a24_25", 32'({a[25], a[24]}), 32'b01);

        // CB prefix suppresses the pending interrupt
        drive(1, 1, 1, 1, 8'h37, 0);
        tick("cb");
        chk("cb.CB_ACT", 32'(CB_ACT), 32'd1);
        chk("cb.a3", 32'(a[3]), 32'd1);
        chk("cb.a1", 32'(a[1]), 32'd0);
        chk("cb.IR", 32'(IR), 32'h37);
        chk("cb.ack", 32'(INT_ACK), 32'd0);

        // Interrupt entry and one-cycle acknowledge
        drive(1, 1, 0, 1, 8'hFF, 0);
        tick("irq");
        chk("irq.IR", 32'(IR), 32'h00);
        chk("irq.a1", 32'(a[1]), 32'd1);
        chk("irq.ack", 32'(INT_ACK), 32'd1);
        drive(0, 0, 0, 1, 8'hFF, 0);
        tick("irq2");
        chk("irq2.ack", 32'(INT_ACK), 32'd0);
        // Back-to-back dispatch
        drive(1, 1, 0, 1, 8'h5A, 0);
        tick("b2b");
        chk("b2b.a1", 32'(a[1]), 32'd1);
        chk("b2b.ack", 32'(INT_ACK), 32'd0);
        drive(0, 0, 0, 0, 8'h00, 0);
        tick("b2b2");

        // HALT freezes everything
        for (int i = 0; i < 3; i++) begin
            drive(1, i[0], 0, 0, 8'hAA, 1);
            tick("halt");
        end
        chk("halt.IR", 32'(IR), 32'h00);
        chk("halt.MCYC", 32'(MCYC), 32'd0);

        // Saturation at 7
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, 0, 0, 8'h00, 0);
            tick("sat");
        end
        chk("sat.MCYC", 32'(MCYC), 32'd7);

        // Async reset mid-sequence
        drive(0, 0, 0, 0, 8'h00, 0);
        #2 RESET = 1'b1;
        #1;
        chk("arst.a", 32'(a), 32'h2AAAAA5);
        chk("arst.IR", 32'(IR), 32'h00);
        chk("arst.MCYC", 32'(MCYC), 32'd0);
        model_reset();
        @(posedge CLK);
        #1 RESET = 1'b0;
        tick("post_rst");

        // Randomized run
        for (int n = 0; n < 600; n++) begin
            M_END     = ($urandom_range(0, 1) == 0);
            INSTR_END = ($urandom_range(0, 2) == 0);
            CB_NEXT   = ($urandom_range(0, 3) == 0);
            IRQ_REQ   = ($urandom_range(0, 2) == 0);
            HALT      = ($urandom_range(0, 4) == 0);
            D         = 8'($urandom);
            RESET     = ($urandom_range(0, 49) == 0);
            tick("rnd");
        end
        RESET = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
